usr_write_arbiter: RTL and testbench
====================================

# usr_write_arbiter

Upstream write-request stage for the user-locked register. Arbitrates write requests from up to NUM_USERS agents round-robin and presents one transaction at a time as a (usr_id, data, wr_valid) triple to the locked register's write port. Each grant is acknowledged to its requester. Grants to any ID other than OWNER_ID are counted and flagged, because the downstream register will drop them.

## Interface
- NUM_USERS, default 4: number of requesters; must equal 2**ID_W.
- ID_W, default 2: width of usr_id.
- DATA_W, default 8: width of write data.
- OWNER_ID, default 2: the only ID whose writes the downstream register accepts.
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  NUM_USERS  per-user write request, level; held until the matching ack.
- req_data  in  NUM_USERS*DATA_W  per-user write data; user i occupies bits [i*DATA_W +: DATA_W]; stable while req[i] is high.
- ack  out  NUM_USERS  one-hot, one-cycle pulse to the granted user.
- usr_id  out  ID_W  ID of the current or last granted user; drives the locked register's usr_id.
- data_out  out  DATA_W  data of the current or last grant; drives the locked register's data_in.
- wr_valid  out  1  high for exactly one cycle per grant.
- deny_cnt  out  8  saturating count of grants to non-owner IDs.
- viol  out  1  sticky flag; set on any non-owner grant.
- viol_clr  in  1  synchronous clear of viol only; deny_cnt is not cleared.

## Operation
- FSM states:
  - IDLE: if any req bit is high, select the winner, register usr_id and data_out, and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: wr_valid=1 and ack[usr_id]=1 for this one cycle, then go to COOL.
  - COOL: outputs idle for one cycle, then go to IDLE.
- Winner selection: the first set req bit at or after rr_ptr, searching upward and wrapping NUM_USERS-1 → 0.
- rr_ptr update: on entering COOL, rr_ptr := (usr_id+1) mod NUM_USERS. Wrap from 3 to 0 is required.
- req is sampled only in IDLE. Requests that rise during ISSUE or COOL wait for the next IDLE.
- Non-owner grant: on entering ISSUE with an ID other than OWNER_ID:
  - deny_cnt increments, saturating at 255;
  - viol sets on the same edge.
- Owner grant: no counter change.
- Simultaneous viol_clr and non-owner grant on the same edge: the set wins and viol stays 1.
- usr_id and data_out hold their last values outside ISSUE. They change only on the IDLE→ISSUE edge.
- Reset values:
  - state IDLE, rr_ptr 0;
  - usr_id 0, data_out 0;
  - wr_valid 0, ack 0;
  - deny_cnt 0, viol 0.
- Reset asserted mid-transaction aborts it. No ack is issued for the aborted grant, and the requester must keep req high to be re-served.

## Timing
- Latency: with req[i] high before edge k and state IDLE, the state after edge k is ISSUE. usr_id, data_out, wr_valid and ack[i] are valid from edge k to edge k+1.
- Throughput: one grant per 3 cycles maximum (ISSUE, COOL, IDLE).
- A requester must drop req[i] at or after the edge that ends its ack pulse. If req[i] is still high in the next IDLE, it is treated as a new request.
- The downstream register samples usr_id/data_out on the edge ending the ISSUE cycle.
- viol and deny_cnt update on the IDLE→ISSUE edge, so they are visible during the ISSUE cycle.

## Structure
- Shared package holds:
  - the state enum (IDLE, ISSUE, COOL);
  - the default OWNER_ID constant;
  - the DENY_CNT_MAX=255 constant.
- One sub-module, rr_arbiter: combinational priority search from rr_ptr. Inputs are req and ptr; outputs are a grant index and an any_req flag. The FSM and registers stay in usr_write_arbiter.

## Test plan
- Reset: hold rst_n low → all outputs 0. Release rst_n with req=0 → wr_valid stays 0 for 10 cycles.
- Owner write: req=4'b0100, req_data[2]=8'hA5 → one cycle later usr_id=2, data_out=8'hA5, wr_valid=1, ack=4'b0100 for one cycle; deny_cnt=0, viol=0.
- Round-robin: req=4'b1111 held high, each requester dropping req one cycle after its ack → grant order 0,1,2,3 spaced 3 cycles apart. Then raise req[0] and req[3] with rr_ptr=0 → user 0 is granted first.
- Non-owner write: req[1] with 8'h3C → wr_valid pulse with usr_id=1, deny_cnt=1, viol=1. Assert viol_clr → viol=0, deny_cnt stays 1. Assert viol_clr on the same edge as a new user-1 grant → viol=1.
- Saturation: 260 user-0 grants → deny_cnt stops at 255.
- Reset mid-operation: assert rst_n low during ISSUE → ack and wr_valid drop immediately, rr_ptr=0. After release with req[3] still high → user 3 is re-granted.

Source files
------------

// File: rtl/usr_write_arbiter_pkg.sv
// Shared types and constants for the user write arbiter.
// Imported by the arbiter top and its round-robin search.
package usr_write_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    COOL
  } state_e;

  localparam int OWNER_ID_DEF = 2;

  localparam logic [7:0] DENY_CNT_MAX = 8'd255;

endpackage

// File: rtl/usr_write_arbiter_rr_arbiter.sv
// Round-robin priority search: first set req bit at or after ptr,
// wrapping from the top index back to zero.
module rr_arbiter
  import usr_write_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] gnt_o,
  output logic          any_o
);

  logic [IW-1:0] idx;

  always_comb begin
    gnt_o = '0;
    any_o = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      // IW-bit add wraps naturally since N == 2**IW
      idx = ptr_i + IW'(i);
      if (!any_o && req_i[idx]) begin
        gnt_o = idx;
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/usr_write_arbiter.sv
// Round-robin write-request stage feeding the user-locked register;
// grants to non-owner IDs are counted and flagged.
module usr_write_arbiter
  import usr_write_arbiter_pkg::*;
#(
  parameter int NUM_USERS = 4,
  parameter int ID_W      = 2,
  parameter int DATA_W    = 8,
  parameter int OWNER_ID  = OWNER_ID_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_USERS-1:0]        req,
  input  logic [NUM_USERS*DATA_W-1:0] req_data,
  output logic [NUM_USERS-1:0]        ack,
  output logic [ID_W-1:0]             usr_id,
  output logic [DATA_W-1:0]           data_out,
  output logic                        wr_valid,
  output logic [7:0]                  deny_cnt,
  output logic                        viol,
  input  logic                        viol_clr
);

  state_e                state_q;
  logic [ID_W-1:0]       rr_ptr_q;
  logic [ID_W-1:0]       usr_id_q;
  logic [DATA_W-1:0]     data_q;
  logic                  wr_valid_q;
  logic [NUM_USERS-1:0]  ack_q;
  logic [7:0]            deny_q;
  logic                  viol_q;

  logic [ID_W-1:0]       gnt;
  logic                  any_req;
  logic                  non_owner;

  rr_arbiter #(
    .N  (NUM_USERS),
    .IW (ID_W)
  ) u_rr (
    .req_i (req),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .any_o (any_req)
  );

  assign non_owner = (gnt != ID_W'(OWNER_ID));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      usr_id_q   <= '0;
      data_q     <= '0;
      wr_valid_q <= 1'b0;
      ack_q      <= '0;
      deny_q     <= '0;
      viol_q     <= 1'b0;
    end else begin
      // clear first so a same-edge non-owner grant overrides it
      if (viol_clr) viol_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          wr_valid_q <= 1'b0;
          ack_q      <= '0;
          if (any_req) begin
            state_q    <= ISSUE;
            usr_id_q   <= gnt;
            data_q     <= req_data[gnt*DATA_W +: DATA_W];
            wr_valid_q <= 1'b1;
            ack_q      <= NUM_USERS'(1) << gnt;
            if (non_owner) begin
              viol_q <= 1'b1;
              if (deny_q != DENY_CNT_MAX)
                deny_q <= deny_q + 8'd1;
            end
          end
        end
        ISSUE: begin
          state_q    <= COOL;
          wr_valid_q <= 1'b0;
          ack_q      <= '0;
          rr_ptr_q   <= usr_id_q + ID_W'(1);
        end
        COOL: begin
          state_q    <= IDLE;
          wr_valid_q <= 1'b0;
          ack_q      <= '0;
        end
        default: begin
          state_q    <= IDLE;
          wr_valid_q <= 1'b0;
          ack_q      <= '0;
        end
      endcase
    end
  end

  assign ack      = ack_q;
  assign usr_id   = usr_id_q;
  assign data_out = data_q;
  assign wr_valid = wr_valid_q;
  assign deny_cnt = deny_q;
  assign viol     = viol_q;

endmodule

// File: tb/tb_usr_write_arbiter.sv
// Directed, table-driven bench for usr_write_arbiter.
module tb_usr_write_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic            viol_clr;
  logic [N-1:0]    ack;
  logic [IW-1:0]   usr_id;
  logic [DW-1:0]   data_out;
  logic            wr_valid;
  logic [7:0]      deny_cnt;
  logic            viol;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  usr_write_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .usr_id   (usr_id),
    .data_out (data_out),
    .wr_valid (wr_valid),
    .deny_cnt (deny_cnt),
    .viol     (viol),
    .viol_clr (viol_clr)
  );

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic        clr;
    logic [1:0]  id;
    logic [7:0]  dout;
    logic [7:0]  deny;
    logic        viol;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called from IDLE just after an edge; returns in the ISSUE cycle.
  task automatic grant(input logic [3:0] r, input logic [31:0] d,
                       input logic c);
    req      = r;
    req_data = d;
    viol_clr = c;
    step();
    viol_clr = 1'b0;
  endtask

  task automatic finish_grant();
    step();
    req = '0;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] expack;

    tbl[0] = '{4'b0100, 32'h00A5_0000, 1'b0, 2'd2, 8'hA5, 8'd0, 1'b0};
    tbl[1] = '{4'b0010, 32'h0000_3C00, 1'b0, 2'd1, 8'h3C, 8'd1, 1'b1};
    tbl[2] = '{4'b0100, 32'h005A_0000, 1'b1, 2'd2, 8'h5A, 8'd1, 1'b0};
    tbl[3] = '{4'b0010, 32'h0000_7700, 1'b1, 2'd1, 8'h77, 8'd2, 1'b1};
    tbl[4] = '{4'b1010, 32'h9900_1100, 1'b0, 2'd3, 8'h99, 8'd3, 1'b1};
    tbl[5] = '{4'b1010, 32'h9900_1100, 1'b0, 2'd1, 8'h11, 8'd4, 1'b1};
    tbl[6] = '{4'b0101, 32'h0044_0022, 1'b1, 2'd2, 8'h44, 8'd4, 1'b0};
    tbl[7] = '{4'b0011, 32'h0000_E2E1, 1'b0, 2'd0, 8'hE1, 8'd5, 1'b1};

    rst_n    = 1'b0;
    req      = '0;
    req_data = '0;
    viol_clr = 1'b0;
    repeat (3) step();
    chk("rst_wr_valid", 32'(wr_valid), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_usr_id", 32'(usr_id), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_deny", 32'(deny_cnt), 32'd0);
    chk("rst_viol", 32'(viol), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_wr_valid", 32'(wr_valid), 32'd0);
    end

    for (int v = 0; v < 8; v++) begin
      expack = 4'b0001 << tbl[v].id;
      grant(tbl[v].req, tbl[v].data, tbl[v].clr);
      chk($sformatf("v%0d_wr_valid", v), 32'(wr_valid), 32'd1);
      chk($sformatf("v%0d_ack", v), 32'(ack), 32'(expack));
      chk($sformatf("v%0d_usr_id", v), 32'(usr_id), 32'(tbl[v].id));
      chk($sformatf("v%0d_data", v), 32'(data_out), 32'(tbl[v].dout));
      chk($sformatf("v%0d_deny", v), 32'(deny_cnt), 32'(tbl[v].deny));
      chk($sformatf("v%0d_viol", v), 32'(viol), 32'(tbl[v].viol));
      step();
      req = '0;
      chk($sformatf("v%0d_pulse_wv", v), 32'(wr_valid), 32'd0);
      chk($sformatf("v%0d_pulse_ack", v), 32'(ack), 32'd0);
      chk($sformatf("v%0d_hold_id", v), 32'(usr_id), 32'(tbl[v].id));
      chk($sformatf("v%0d_hold_data", v), 32'(data_out), 32'(tbl[v].dout));
      step();
    end

    viol_clr = 1'b1;
    step();
    viol_clr = 1'b0;
    chk("clr_viol", 32'(viol), 32'd0);
    chk("clr_deny_kept", 32'(deny_cnt), 32'd5);

    // round robin from a fresh pointer
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req_data = 32'h4433_2211;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("rr%0d_wv", i), 32'(wr_valid), 32'd1);
      chk($sformatf("rr%0d_id", i), 32'(usr_id), 32'(i));
      chk($sformatf("rr%0d_data", i), 32'(data_out), 32'(8'h11 * (i + 1)));
      step();
      req[i] = 1'b0;
      chk($sformatf("rr%0d_cool_wv", i), 32'(wr_valid), 32'd0);
      step();
      chk($sformatf("rr%0d_idle_wv", i), 32'(wr_valid), 32'd0);
    end
    req = 4'b1001;
    step();
    chk("rr_wrap_id0", 32'(usr_id), 32'd0);
    chk("rr_wrap_wv0", 32'(wr_valid), 32'd1);
    step();
    req[0] = 1'b0;
    step();
    step();
    chk("rr_wrap_id3", 32'(usr_id), 32'd3);
    chk("rr_wrap_ack3", 32'(ack), 32'b1000);
    finish_grant();
    chk("rr_deny", 32'(deny_cnt), 32'd5);

    // saturation
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 260; k++) begin
      grant(4'b0001, 32'h0000_00AB, 1'b0);
      if (k == 254) chk("sat_at_255", 32'(deny_cnt), 32'd255);
      finish_grant();
    end
    chk("sat_final", 32'(deny_cnt), 32'd255);
    chk("sat_viol", 32'(viol), 32'd1);

    // reset during ISSUE
    grant(4'b1000, 32'hC300_0000, 1'b0);
    chk("mr_wv_before", 32'(wr_valid), 32'd1);
    chk("mr_ack_before", 32'(ack), 32'b1000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_wv", 32'(wr_valid), 32'd0);
    chk("mr_ack", 32'(ack), 32'd0);
    chk("mr_id", 32'(usr_id), 32'd0);
    chk("mr_deny", 32'(deny_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("mr_regrant_id", 32'(usr_id), 32'd3);
    chk("mr_regrant_wv", 32'(wr_valid), 32'd1);
    chk("mr_regrant_data", 32'(data_out), 32'hC3);
    finish_grant();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
